// File: rtl/hicore_lsu_pkg.sv
// Shared definitions for the HiCore load/store unit.
//   - info word layout {rob_ptr, pc, irq, excp} with excp in the low bits
//   - exception bit indices inside the excp field
//   - LSU controller state encoding
package hicore_lsu_pkg;

  localparam int LSU_AW     = 32;
  localparam int LSU_DW     = 32;
  localparam int LSU_EXCP_W = 16;
  localparam int LSU_ROB_W  = 15;
  localparam int LSU_INFO_W = LSU_ROB_W + 32 + 1 + LSU_EXCP_W;

  // Field offsets inside the info word.
  localparam int EXCP_LSB = 0;
  localparam int IRQ_BIT  = LSU_EXCP_W;
  localparam int PC_LSB   = LSU_EXCP_W + 1;
  localparam int ROB_LSB  = LSU_EXCP_W + 1 + 32;

  // Exception bit indices inside the excp field.
  localparam int LD_MISALIGN = 4;
  localparam int LD_FAULT    = 5;
  localparam int ST_MISALIGN = 6;
  localparam int ST_FAULT    = 7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RSP   = 3'd2,
    S_WB    = 3'd3,
    S_DRAIN = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/hicore_lsu_if.sv
// Single-outstanding data-memory bus between the LSU and data memory.
//   master (LSU)    : drives request fields, receives ready and response
//   slave  (memory) : receives request, drives ready and response
// Responses carry no ready; the master always accepts them.
interface hicore_lsu_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            dmem_req_valid;
  logic            dmem_req_ready;
  logic            dmem_req_write;
  logic [AW-1:0]   dmem_req_addr;
  logic [DW-1:0]   dmem_req_wdata;
  logic [DW/8-1:0] dmem_req_wmask;
  logic            dmem_rsp_valid;
  logic [DW-1:0]   dmem_rsp_data;
  logic            dmem_rsp_err;

  modport master (
    output dmem_req_valid, dmem_req_write, dmem_req_addr, dmem_req_wdata, dmem_req_wmask,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_data, dmem_rsp_err
  );

  modport slave (
    input  dmem_req_valid, dmem_req_write, dmem_req_addr, dmem_req_wdata, dmem_req_wmask,
    output dmem_req_ready, dmem_rsp_valid, dmem_rsp_data, dmem_rsp_err
  );
endinterface

// File: rtl/hicore_lsu_ldext.sv
// Load data align/extend (combinational).
//   rsp_data    : raw read word from memory
//   addr_lo     : byte offset of the access within the word
//   is_byte/is_short/is_word : access size, one-hot
//   is_unsigned : zero-extend instead of sign-extend
//   ext         : aligned, extended load value
module hicore_lsu_ldext
  import hicore_lsu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0]        rsp_data,
  input  logic [1:0]           addr_lo,
  input  logic                 is_byte,
  input  logic                 is_short,
  input  logic                 is_word,
  input  logic                 is_unsigned,
  output logic signed [DW-1:0] ext
);

  function automatic logic signed [DW-1:0] extend_byte(input logic [7:0] b, input logic uns);
    return {{(DW-8){b[7] & ~uns}}, b};
  endfunction

  function automatic logic signed [DW-1:0] extend_short(input logic [15:0] h, input logic uns);
    return {{(DW-16){h[15] & ~uns}}, h};
  endfunction

  logic [DW-1:0] shifted;

  always_comb begin
    shifted = rsp_data >> {addr_lo, 3'b000};
    ext     = shifted;
    case ({is_byte, is_short, is_word})
      3'b100:  ext = extend_byte(shifted[7:0], is_unsigned);
      3'b010:  ext = extend_short(shifted[15:0], is_unsigned);
      default: ext = shifted;
    endcase
  end

endmodule

// File: rtl/hicore_lsu.sv
// HiCore load/store unit.
// Accepts one decoded memory op from address generation, issues it on the
// single-outstanding data bus, aligns/extends load data and hands the result
// plus the exception-updated info word to writeback. Flush and cancel discard
// work; a flushed op whose request already left waits in DRAIN for its
// response so the bus never has two transactions in flight.
//   clk, rst          : clock, asynchronous active-high reset
//   i_agu2lsu_*       : incoming op handshake and fields
//   dmem              : data-memory bus (master side)
//   o_lsu2wb_*        : writeback handshake and result
//   flush             : commit flush
module hicore_lsu
  import hicore_lsu_pkg::*;
#(
  parameter int AW     = LSU_AW,
  parameter int DW     = LSU_DW,
  parameter int INFO_W = LSU_INFO_W,
  parameter int EXCP_W = LSU_EXCP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_agu2lsu_valid,
  output logic              i_agu2lsu_ready,
  input  logic              i_agu2lsu_cancel,
  input  logic              i_agu2lsu_read,
  input  logic              i_agu2lsu_unsigned,
  input  logic              i_agu2lsu_word_access,
  input  logic              i_agu2lsu_short_access,
  input  logic              i_agu2lsu_byte_access,
  input  logic [AW-1:0]     i_agu2lsu_addr,
  input  logic [DW-1:0]     i_agu2lsu_wdata,
  input  logic [DW/8-1:0]   i_agu2lsu_wmask,
  input  logic [INFO_W-1:0] i_agu2lsu_info,
  hicore_lsu_if.master      dmem,
  output logic              o_lsu2wb_valid,
  input  logic              i_lsu2wb_ready,
  output logic              o_lsu2wb_wen,
  output logic [DW-1:0]     o_lsu2wb_data,
  output logic [INFO_W-1:0] o_lsu2wb_info,
  input  logic              flush
);

  lsu_state_e state_q, state_d;

  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;
  logic [DW/8-1:0]   wmask_q;
  logic              read_q;
  logic              unsigned_q;
  logic [2:0]        size_q;   // {byte, short, word}
  logic [INFO_W-1:0] info_q;
  logic              wen_q;
  logic [DW-1:0]     data_q;

  logic signed [DW-1:0] ld_ext;
  logic                 in_excp;
  logic                 req_fire;

  assign in_excp  = |i_agu2lsu_info[EXCP_LSB +: EXCP_W];
  assign req_fire = dmem.dmem_req_valid & dmem.dmem_req_ready;

  hicore_lsu_ldext #(.DW(DW)) u_ldext (
    .rsp_data    (dmem.dmem_rsp_data),
    .addr_lo     (addr_q[1:0]),
    .is_byte     (size_q[2]),
    .is_short    (size_q[1]),
    .is_word     (size_q[0]),
    .is_unsigned (unsigned_q),
    .ext         (ld_ext)
  );

  // Controller state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_agu2lsu_valid && !i_agu2lsu_cancel && !flush)
          state_d = in_excp ? S_WB : S_REQ;
      end
      S_REQ: begin
        if (req_fire) state_d = flush ? S_DRAIN : S_RSP;
        else if (flush) state_d = S_IDLE;
      end
      S_RSP: begin
        // A response coinciding with flush retires the transaction outright.
        if (dmem.dmem_rsp_valid) state_d = flush ? S_IDLE : S_WB;
        else if (flush)          state_d = S_DRAIN;
      end
      S_WB: begin
        if (flush || i_lsu2wb_ready) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (dmem.dmem_rsp_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Op capture and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      read_q     <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= '0;
      info_q     <= '0;
      wen_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_agu2lsu_valid) begin
            addr_q     <= i_agu2lsu_addr;
            wdata_q    <= i_agu2lsu_wdata;
            wmask_q    <= i_agu2lsu_wmask;
            read_q     <= i_agu2lsu_read;
            unsigned_q <= i_agu2lsu_unsigned;
            size_q     <= {i_agu2lsu_byte_access, i_agu2lsu_short_access, i_agu2lsu_word_access};
            info_q     <= i_agu2lsu_info;
            wen_q      <= 1'b0;
            data_q     <= '0;
          end
        end
        S_RSP: begin
          if (dmem.dmem_rsp_valid && !flush) begin
            if (dmem.dmem_rsp_err) begin
              info_q[EXCP_LSB + (read_q ? LD_FAULT : ST_FAULT)] <= 1'b1;
              wen_q  <= 1'b0;
              data_q <= '0;
            end else begin
              wen_q  <= read_q;
              data_q <= read_q ? ld_ext : '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign i_agu2lsu_ready     = (state_q == S_IDLE);
  assign dmem.dmem_req_valid = (state_q == S_REQ);
  assign dmem.dmem_req_write = ~read_q;
  assign dmem.dmem_req_addr  = {addr_q[AW-1:2], 2'b00};
  assign dmem.dmem_req_wdata = wdata_q;
  assign dmem.dmem_req_wmask = read_q ? '0 : wmask_q;

  assign o_lsu2wb_valid = (state_q == S_WB);
  assign o_lsu2wb_wen   = wen_q;
  assign o_lsu2wb_data  = data_q;
  assign o_lsu2wb_info  = info_q;

endmodule

// File: tb/tb_hicore_lsu.sv
// Directed bench for hicore_lsu: drives ops and bus responses on the falling
// edge and compares outputs against hand-computed values on the falling edge.
module tb_hicore_lsu;
  import hicore_lsu_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = LSU_INFO_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          agu_valid, agu_ready, agu_cancel, agu_read, agu_unsigned;
  logic          agu_word, agu_short, agu_byte;
  logic [AW-1:0] agu_addr;
  logic [DW-1:0] agu_wdata;
  logic [3:0]    agu_wmask;
  logic [IW-1:0] agu_info;
  logic          wb_valid, wb_ready, wb_wen;
  logic [DW-1:0] wb_data;
  logic [IW-1:0] wb_info;
  logic          flush;

  hicore_lsu_if #(.AW(AW), .DW(DW)) dmem_bus ();

  hicore_lsu u_dut (
    .clk                    (clk),
    .rst                    (rst),
    .i_agu2lsu_valid        (agu_valid),
    .i_agu2lsu_ready        (agu_ready),
    .i_agu2lsu_cancel       (agu_cancel),
    .i_agu2lsu_read         (agu_read),
    .i_agu2lsu_unsigned     (agu_unsigned),
    .i_agu2lsu_word_access  (agu_word),
    .i_agu2lsu_short_access (agu_short),
    .i_agu2lsu_byte_access  (agu_byte),
    .i_agu2lsu_addr         (agu_addr),
    .i_agu2lsu_wdata        (agu_wdata),
    .i_agu2lsu_wmask        (agu_wmask),
    .i_agu2lsu_info         (agu_info),
    .dmem                   (dmem_bus.master),
    .o_lsu2wb_valid         (wb_valid),
    .i_lsu2wb_ready         (wb_ready),
    .o_lsu2wb_wen           (wb_wen),
    .o_lsu2wb_data          (wb_data),
    .o_lsu2wb_info          (wb_info),
    .flush                  (flush)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int req_cnt = 0;
  int wb_cnt  = 0;

  always @(posedge clk) begin
    if (dmem_bus.dmem_req_valid && dmem_bus.dmem_req_ready) req_cnt <= req_cnt + 1;
    if (wb_valid) wb_cnt <= wb_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present one op for a single cycle; returns at the falling edge of the
  // cycle after acceptance.
  task automatic issue(input logic rd, input logic uns, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm,
                       input logic [IW-1:0] inf, input logic canc);
    @(negedge clk);
    agu_valid    = 1'b1;
    agu_read     = rd;
    agu_unsigned = uns;
    {agu_byte, agu_short, agu_word} = sz;
    agu_addr     = a;
    agu_wdata    = wd;
    agu_wmask    = wm;
    agu_info     = inf;
    agu_cancel   = canc;
    @(negedge clk);
    agu_valid  = 1'b0;
    agu_cancel = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d, input logic err);
    dmem_bus.dmem_rsp_valid = 1'b1;
    dmem_bus.dmem_rsp_data  = d;
    dmem_bus.dmem_rsp_err   = err;
    @(negedge clk);
    dmem_bus.dmem_rsp_valid = 1'b0;
    dmem_bus.dmem_rsp_err   = 1'b0;
  endtask

  // Simple load with immediate bus acceptance and response.
  task automatic load_case(input string tag, input logic uns, input logic [2:0] sz,
                           input logic [31:0] a, input logic [31:0] rd, input logic [31:0] exp);
    issue(1'b1, uns, sz, a, 32'h0, 4'h0, '0, 1'b0);
    @(negedge clk);
    respond(rd, 1'b0);
    chk({tag, "_valid"}, 64'(wb_valid), 64'd1);
    chk({tag, "_data"}, 64'(wb_data), 64'(exp));
    @(negedge clk);
  endtask

  localparam logic [2:0] SZ_BYTE  = 3'b100;
  localparam logic [2:0] SZ_SHORT = 3'b010;
  localparam logic [2:0] SZ_WORD  = 3'b001;

  localparam logic [IW-1:0] INFO1 = 64'h0001_2345_6789_0000;
  localparam logic [IW-1:0] INFO4 = 64'h0002_0000_1111_0010;
  localparam logic [IW-1:0] INFO6 = 64'h0003_0000_2222_0000;

  int base;

  initial begin
    rst = 1'b1;
    agu_valid = 0; agu_cancel = 0; agu_read = 0; agu_unsigned = 0;
    agu_word = 0; agu_short = 0; agu_byte = 0;
    agu_addr = '0; agu_wdata = '0; agu_wmask = '0; agu_info = '0;
    wb_ready = 1'b1; flush = 1'b0;
    dmem_bus.dmem_req_ready = 1'b1;
    dmem_bus.dmem_rsp_valid = 1'b0;
    dmem_bus.dmem_rsp_data  = '0;
    dmem_bus.dmem_rsp_err   = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_agu_ready", 64'(agu_ready), 64'd1);
    chk("rst_req_valid", 64'(dmem_bus.dmem_req_valid), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    chk("rst_wb_info", 64'(wb_info), 64'd0);
    chk("rst_req_addr", 64'(dmem_bus.dmem_req_addr), 64'd0);
    rst = 1'b0;

    // Signed byte load with full latency trace.
    issue(1'b1, 1'b0, SZ_BYTE, 32'h1003, 32'h0, 4'h0, INFO1, 1'b0);
    chk("t1_req_valid", 64'(dmem_bus.dmem_req_valid), 64'd1);
    chk("t1_req_addr", 64'(dmem_bus.dmem_req_addr), 64'h1000);
    chk("t1_req_write", 64'(dmem_bus.dmem_req_write), 64'd0);
    chk("t1_req_wmask", 64'(dmem_bus.dmem_req_wmask), 64'd0);
    chk("t1_agu_ready", 64'(agu_ready), 64'd0);
    @(negedge clk);
    chk("t1_rsp_wb_valid", 64'(wb_valid), 64'd0);
    chk("t1_rsp_req_valid", 64'(dmem_bus.dmem_req_valid), 64'd0);
    respond(32'h80FF_1234, 1'b0);
    chk("t1_wb_valid", 64'(wb_valid), 64'd1);
    chk("t1_wb_data", 64'(wb_data), 64'hFFFF_FF80);
    chk("t1_wb_wen", 64'(wb_wen), 64'd1);
    chk("t1_wb_info", 64'(wb_info), 64'(INFO1));
    @(negedge clk);
    chk("t1_done_wb_valid", 64'(wb_valid), 64'd0);
    chk("t1_done_agu_ready", 64'(agu_ready), 64'd1);

    // Short loads, unsigned and signed; word load with unused offset bits.
    load_case("t2_ushort", 1'b1, SZ_SHORT, 32'h2002, 32'hBEEF_0000, 32'h0000_BEEF);
    load_case("t2_sshort", 1'b0, SZ_SHORT, 32'h2002, 32'hBEEF_0000, 32'hFFFF_BEEF);
    load_case("t2_ubyte", 1'b1, SZ_BYTE, 32'h2001, 32'h1234_9A78, 32'h0000_009A);
    load_case("t2_word", 1'b0, SZ_WORD, 32'h2004, 32'h8765_4321, 32'h8765_4321);

    // Store word with bus stalled for three cycles.
    dmem_bus.dmem_req_ready = 1'b0;
    base = req_cnt;
    issue(1'b0, 1'b0, SZ_WORD, 32'h3000, 32'hDEAD_BEEF, 4'hF, INFO1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("t3_req_valid", 64'(dmem_bus.dmem_req_valid), 64'd1);
      chk("t3_req_addr", 64'(dmem_bus.dmem_req_addr), 64'h3000);
      chk("t3_req_wdata", 64'(dmem_bus.dmem_req_wdata), 64'hDEAD_BEEF);
      chk("t3_req_wmask", 64'(dmem_bus.dmem_req_wmask), 64'hF);
      chk("t3_req_write", 64'(dmem_bus.dmem_req_write), 64'd1);
      @(negedge clk);
    end
    dmem_bus.dmem_req_ready = 1'b1;
    @(negedge clk);
    chk("t3_req_gone", 64'(dmem_bus.dmem_req_valid), 64'd0);
    chk("t3_req_count", 64'(req_cnt - base), 64'd1);
    respond(32'h5555_5555, 1'b0);
    chk("t3_wb_valid", 64'(wb_valid), 64'd1);
    chk("t3_wb_wen", 64'(wb_wen), 64'd0);
    chk("t3_wb_data", 64'(wb_data), 64'd0);
    @(negedge clk);

    // Incoming exception bypasses the bus.
    base = req_cnt;
    issue(1'b1, 1'b0, SZ_WORD, 32'h4000, 32'h0, 4'h0, INFO4, 1'b0);
    chk("t4_wb_valid", 64'(wb_valid), 64'd1);
    chk("t4_req_valid", 64'(dmem_bus.dmem_req_valid), 64'd0);
    chk("t4_wb_info", 64'(wb_info), 64'(INFO4));
    chk("t4_wb_wen", 64'(wb_wen), 64'd0);
    @(negedge clk);
    chk("t4_req_count", 64'(req_cnt - base), 64'd0);
    chk("t4_idle", 64'(agu_ready), 64'd1);

    // Cancelled op is dropped.
    issue(1'b1, 1'b0, SZ_WORD, 32'h4800, 32'h0, 4'h0, INFO1, 1'b1);
    chk("tc_agu_ready", 64'(agu_ready), 64'd1);
    chk("tc_req_valid", 64'(dmem_bus.dmem_req_valid), 64'd0);

    // Flush after the request is accepted: drain the late response.
    base = wb_cnt;
    issue(1'b1, 1'b0, SZ_WORD, 32'h4100, 32'h0, 4'h0, INFO1, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t5_drain_ready", 64'(agu_ready), 64'd0);
    @(negedge clk);
    chk("t5_drain_ready2", 64'(agu_ready), 64'd0);
    respond(32'hCAFE_F00D, 1'b0);
    chk("t5_ready_back", 64'(agu_ready), 64'd1);
    chk("t5_no_wb", 64'(wb_cnt - base), 64'd0);

    // Load bus error, writeback held while stalled.
    wb_ready = 1'b0;
    issue(1'b1, 1'b0, SZ_WORD, 32'h5000, 32'h0, 4'h0, INFO6, 1'b0);
    @(negedge clk);
    respond(32'h1234_5678, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("t6_wb_valid", 64'(wb_valid), 64'd1);
      chk("t6_wb_wen", 64'(wb_wen), 64'd0);
      chk("t6_wb_data", 64'(wb_data), 64'd0);
      chk("t6_wb_info", 64'(wb_info), 64'(INFO6 | 64'h20));
      @(negedge clk);
    end
    wb_ready = 1'b1;
    @(negedge clk);
    chk("t6_wb_done", 64'(wb_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hicore_lsu.md
Name: hicore_lsu

Overview:
Load/store unit directly downstream of the address-generation stage. Accepts one decoded memory operation per handshake and issues it on the single-outstanding data-memory bus. For loads, it aligns and sign- or zero-extends the returned data. It then hands the result plus the exception-updated info word to writeback/ROB, and discards work on flush or cancel.

Parameters:
AW, 32, address width (HiCore_ADDR_SIZE)
DW, 32, data width (HiCore_REG_SIZE); wmask width DW/8
INFO_W, HiCore_ISSUE2ALU_SIZE, info word {rob_ptr,pc,irq,excp}
EXCP_W, 16, excp field width, located at info[EXCP_W-1:0]

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_agu2lsu_valid  in  1  op valid
i_agu2lsu_ready  out  1  LSU accepts op
i_agu2lsu_cancel  in  1  op is cancelled: accept and drop
i_agu2lsu_read  in  1  1=load, 0=store
i_agu2lsu_unsigned  in  1  zero-extend load
i_agu2lsu_word_access / _short_access / _byte_access  in  1 each  size one-hot
i_agu2lsu_addr  in  AW  byte address
i_agu2lsu_wdata  in  DW  lane-replicated store data
i_agu2lsu_wmask  in  DW/8  byte enables
i_agu2lsu_info  in  INFO_W  rob_ptr/pc/irq/excp
o_dmem_req_valid  out  1  bus request
i_dmem_req_ready  in  1  bus accepts request
o_dmem_req_write  out  1  store
o_dmem_req_addr  out  AW  word-aligned address {addr[AW-1:2],2'b00}
o_dmem_req_wdata  out  DW  store data
o_dmem_req_wmask  out  DW/8  byte enables (0 for loads)
i_dmem_rsp_valid  in  1  response (always accepted)
i_dmem_rsp_data  in  DW  read word
i_dmem_rsp_err  in  1  bus error
o_lsu2wb_valid  out  1  result valid
i_lsu2wb_ready  in  1  writeback accepts
o_lsu2wb_wen  out  1  1 for loads without exception
o_lsu2wb_data  out  DW  extended load data (0 for stores)
o_lsu2wb_info  out  INFO_W  info with updated excp
flush  in  1  commit flush

Behaviour:
- Reset: state=IDLE. o_dmem_req_valid=0, o_lsu2wb_valid=0, i_agu2lsu_ready=1. All data registers are 0.
- States: IDLE, REQ, RSP, WB, DRAIN.
- IDLE: i_agu2lsu_ready=1. Capture on valid.
  - cancel=1 or flush=1: drop and stay in IDLE.
  - info excp!=0: go to WB with wen=0 and no bus access.
  - Otherwise: go to REQ.
- REQ: o_dmem_req_valid=1 and request fields are held stable.
  - Request accepted (req_valid & req_ready): go to RSP.
  - flush with no request accepted: go to IDLE.
  - flush in the same cycle the request is accepted: go to DRAIN.
- RSP: wait for rsp_valid, then register the result and go to WB.
  - flush: go to DRAIN.
  - rsp_valid and flush in the same cycle: go to IDLE, result discarded.
- Load data extraction: shift = addr[1:0]*8, applied to rsp_data.
  - byte: bits [7:0] of the shifted word, extended to DW.
  - short: bits [15:0], extended to DW.
  - word: used unchanged.
  - Sign extension unless unsigned=1.
- rsp_err: set excp bit5 for a load or bit7 for a store (OR into the existing field). Force wen=0 and data=0.
- WB: o_lsu2wb_valid=1 and outputs are held stable until i_lsu2wb_ready.
  - On ready: go to IDLE. No same-cycle re-accept (i_agu2lsu_ready=0 outside IDLE).
  - flush in WB: drop and go to IDLE.
- DRAIN: ignore all inputs except the response; on rsp_valid go to IDLE. Never emits writeback.
- Latency: accept(t) → req_valid t+1 → accepted at t+1 with ready=1 → rsp earliest t+2 → wb_valid t+3.
- At most one bus transaction is outstanding. Responses arriving outside RSP/DRAIN are ignored.
- Reset mid-transaction returns to IDLE immediately. A bus in flight is the system's responsibility.

Decomposition:
- Shared package: info field offsets, EXCP bit indices (LD_MISALIGN=4, LD_FAULT=5, ST_MISALIGN=6, ST_FAULT=7), and the state encoding.
- One sub-module, hicore_lsu_ldext: combinational align/extend from (rsp_data, addr[1:0], size one-hot, unsigned) to DW.

Test Plan:
1. Signed byte load: addr=0x1003, rsp_data=0x80FF_1234 → wb data=0xFFFF_FF80, wen=1, wb_valid 3 cycles after accept with req_ready=1.
2. Unsigned short load: addr=0x2002, rsp_data=0xBEEF_0000 → data=0x0000_BEEF. Signed variant → 0xFFFF_BEEF.
3. Store word: addr=0x3000, wdata=0xDEADBEEF, wmask=4'hF, req_ready low for 3 cycles → request fields held stable, one request issued; wb wen=0, data=0.
4. Incoming excp bit4 set → no o_dmem_req_valid ever asserted; wb_valid next cycle with info excp unchanged.
5. flush one cycle after the request is accepted, response 2 cycles later → no wb_valid; i_agu2lsu_ready returns to 1 the cycle after rsp_valid.
6. rsp_err on a load → excp bit5 set, wen=0. wb held 4 cycles with i_lsu2wb_ready=0 → outputs stable throughout.
